// File: rtl/clic_irq_arbiter.sv
// clic_irq_arbiter
//   Picks the highest-priority eligible CLIC interrupt (pending & enabled),
//   registers the winner, and offers it to the hart over valid/ready. An
//   offer that loses eligibility or is outranked is withdrawn through a
//   kill request/ack exchange. After an accepted offer, edge-triggered
//   sources get a one-cycle claim pulse, followed by a short cooldown.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   ip_i, ie_i           per-source pending / enable
//   le_i                 per-source edge-triggered flag
//   shv_i                per-source selective hardware vectoring
//   prio_i               per-source intctl, packed source i at [i*PrioWidth +: PrioWidth]
//   claim_o              one-hot pulse clearing the accepted edge source
//   irq_valid_o/ready_i  offer handshake to the core
//   irq_id_o/level_o/shv_o  offered interrupt, stable while offered
//   irq_kill_req_o/ack_i    withdrawal of an offered interrupt
//
// state    | meaning
// IDLE     | nothing offered; waiting for a registered winner
// ACTIVE   | offer presented to the core
// KILL     | offer withdrawn, waiting for the core to acknowledge
// COOLDOWN | post-accept wait so cleared pending bits reach best_*_q
module clic_irq_arbiter #(
  parameter int N_SOURCE  = 32,
  parameter int PrioWidth = 8,
  localparam int SrcW     = $clog2(N_SOURCE)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_SOURCE-1:0]           ip_i,
  input  logic [N_SOURCE-1:0]           ie_i,
  input  logic [N_SOURCE-1:0]           le_i,
  input  logic [N_SOURCE-1:0]           shv_i,
  input  logic [N_SOURCE*PrioWidth-1:0] prio_i,
  output logic [N_SOURCE-1:0]           claim_o,
  output logic                          irq_valid_o,
  input  logic                          irq_ready_i,
  output logic [SrcW-1:0]               irq_id_o,
  output logic [PrioWidth-1:0]          irq_level_o,
  output logic                          irq_shv_o,
  output logic                          irq_kill_req_o,
  input  logic                          irq_kill_ack_i
);

  typedef enum logic [1:0] {IDLE, ACTIVE, KILL, COOLDOWN} state_e;

  // Loaded on accept and counted down to zero: two cooldown cycles.
  localparam logic [1:0] CoolLoad = 2'd1;

  logic                 sel_valid;
  logic [SrcW-1:0]      sel_id;
  logic [PrioWidth-1:0] sel_prio;
  logic                 sel_shv;

  logic                 best_valid_q;
  logic [SrcW-1:0]      best_id_q;
  logic [PrioWidth-1:0] best_prio_q;
  logic                 best_shv_q;

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [N_SOURCE-1:0]  claim_q, claim_d;
  logic [SrcW-1:0]      id_q, id_d;
  logic [PrioWidth-1:0] level_q, level_d;
  logic                 shv_q, shv_d;

  // Linear scan; strict greater-than keeps the lower index on ties.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    sel_prio  = '0;
    sel_shv   = 1'b0;
    for (int i = 0; i < N_SOURCE; i++) begin
      if (ip_i[i] && ie_i[i]) begin
        if (!sel_valid || (prio_i[i*PrioWidth +: PrioWidth] > sel_prio)) begin
          sel_valid = 1'b1;
          sel_id    = SrcW'(i);
          sel_prio  = prio_i[i*PrioWidth +: PrioWidth];
          sel_shv   = shv_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      best_valid_q <= 1'b0;
      best_id_q    <= '0;
      best_prio_q  <= '0;
      best_shv_q   <= 1'b0;
    end else begin
      best_valid_q <= sel_valid;
      best_id_q    <= sel_id;
      best_prio_q  <= sel_prio;
      best_shv_q   <= sel_shv;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      claim_q <= '0;
      id_q    <= '0;
      level_q <= '0;
      shv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      claim_q <= claim_d;
      id_q    <= id_d;
      level_q <= level_d;
      shv_q   <= shv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    claim_d = '0;
    id_d    = id_q;
    level_d = level_q;
    shv_d   = shv_q;
    unique case (state_q)
      IDLE: begin
        if (best_valid_q) begin
          id_d    = best_id_q;
          level_d = best_prio_q;
          shv_d   = best_shv_q;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // Acceptance wins over preemption/withdrawal in the same cycle.
        if (irq_ready_i) begin
          claim_d[id_q] = le_i[id_q];
          cnt_d         = CoolLoad;
          state_d       = COOLDOWN;
        end else if (!best_valid_q || (best_prio_q > level_q)) begin
          state_d = KILL;
        end
      end
      KILL: begin
        if (irq_kill_ack_i) state_d = IDLE;
      end
      COOLDOWN: begin
        if (cnt_q == 2'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign claim_o        = claim_q;
  assign irq_valid_o    = (state_q == ACTIVE);
  assign irq_kill_req_o = (state_q == KILL);
  assign irq_id_o       = id_q;
  assign irq_level_o    = level_q;
  assign irq_shv_o      = shv_q;

endmodule

// File: doc/clic_irq_arbiter.md
Name: clic_irq_arbiter

Overview:
- Sits directly downstream of the CLIC register adapter.
- Consumes the per-source pending, enable, trigger, SHV and intctl values it produces.
- Selects the highest-priority eligible interrupt through a registered max-tree and presents it to the hart over a valid/ready handshake, with kill/ack for preemption or withdrawal.
- Issues a one-cycle claim pulse that clears edge-triggered pending bits after the core accepts.

Parameters:
N_SOURCE, 32, number of interrupt sources (>=2)
PrioWidth, 8, width of intctl priority/level value
SrcW, $clog2(N_SOURCE), width of interrupt id (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ip_i  in  N_SOURCE  pending per source
ie_i  in  N_SOURCE  enable per source
le_i  in  N_SOURCE  1 = edge-triggered source
shv_i  in  N_SOURCE  selective hardware vectoring per source
prio_i  in  N_SOURCE x PrioWidth  intctl per source
claim_o  out  N_SOURCE  one-hot, 1-cycle pulse clearing edge pending
irq_valid_o  out  1  interrupt request to core
irq_ready_i  in  1  core accepts request
irq_id_o  out  SrcW  id of requested interrupt
irq_level_o  out  PrioWidth  intctl of requested interrupt
irq_shv_o  out  1  SHV of requested interrupt
irq_kill_req_o  out  1  request core to drop offered interrupt
irq_kill_ack_i  in  1  core acknowledges kill

Behaviour:

Eligibility and selection
- Source i is eligible when ip_i[i] & ie_i[i].
- Combinational max over eligible sources by prio_i. On equal priority, the lower index wins.
- Result is registered each cycle into best_valid_q, best_id_q, best_prio_q, best_shv_q. There is no enable; the registers update every edge.

FSM states: IDLE, ACTIVE, KILL, COOLDOWN.
- IDLE:
  - If best_valid_q, latch best_* into irq_id_o, irq_level_o, irq_shv_o and go to ACTIVE.
- ACTIVE:
  - irq_valid_o=1. irq_id_o, irq_level_o and irq_shv_o are held stable.
  - If irq_ready_i: handshake.
    - Next cycle, claim_o[irq_id_o]=1 if le_i[irq_id_o] at the handshake edge; otherwise claim_o stays 0.
    - Go to COOLDOWN.
  - Else if !best_valid_q, or best_prio_q > irq_level_o (strictly greater): go to KILL.
  - Ready has priority over preemption in the same cycle.
- KILL:
  - irq_valid_o=0, irq_kill_req_o=1 until irq_kill_ack_i.
  - On ack: go to IDLE, irq_kill_req_o=0 next cycle.
  - irq_ready_i is ignored in KILL.
- COOLDOWN:
  - Fixed 2-cycle counter; irq_valid_o=0. Covers claim-to-pending-clear propagation through the register file and best_q.
  - Then go to IDLE.

Latency
- Eligible source applied before edge k: best_q updated at edge k, irq_valid_o=1 after edge k+1.

Reset (asynchronous, any state)
- FSM to IDLE; best_* = 0.
- claim_o, irq_valid_o, irq_kill_req_o, irq_id_o, irq_level_o, irq_shv_o all 0.
- Counter 0.

Rules
- claim_o is at most one-hot and never asserted outside the cycle after a handshake.
- irq_valid_o and irq_kill_req_o are never both 1.
- Priority 0 is still eligible; threshold filtering is the core's responsibility.

Test Plan:
- Single source: ip[5]=1, ie[5]=1, prio[5]=0x40, le[5]=1, shv[5]=1 before edge 0.
  -> irq_valid_o=1 after edge 1 with id=5, level=0x40, shv=1.
  -> ready at edge 3 gives claim_o=32'h20 for exactly one cycle, then valid=0 for 2 COOLDOWN cycles.
- Arbitration and tie: sources 3 and 9 both at prio 0x80, source 12 at 0x7F.
  -> id=3. With ie[3]=0, id=9.
  -> Level source (le=0) handshake gives claim_o=0.
- Preemption: ACTIVE on id=2 with level 0x20, then source 7 at 0x90 becomes eligible.
  -> Kill path: irq_kill_req_o=1 and valid=0 two cycles later; ack returns to IDLE; next offer is id=7, level 0x90.
  -> Equal priority 0x20 on source 1 does not kill.
- Withdrawal: level source deasserts ip while ACTIVE -> KILL. Ready and preemption in the same cycle -> handshake wins, no kill.
- Reset mid-operation: rst_ni low in ACTIVE and in KILL -> all outputs 0 immediately (asynchronous); after release, re-arbitration with 2-cycle latency.
- No eligible sources for 100 cycles with random prio/le/shv -> irq_valid_o, irq_kill_req_o and claim_o stay 0.
